// File: rtl/btn_debounce_if.sv
// Button conditioner bus: raw pin levels in, debounced level and event pulses out.
// The slave modport is the conditioner side; the master modport is the user side.
interface btn_debounce_if #(
    parameter int N_BTN = 3
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_state;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;

    modport master (
        output btn_raw,
        input  btn_state,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  btn_raw,
        output btn_state,
        output btn_press,
        output btn_release,
        output btn_long
    );
endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: per-bit polarity fix, 2-FF synchroniser, counter debounce,
// and registered press / release / long-press pulses for each independent channel.
module btn_debounce #(
    parameter int          N_BTN         = 3,
    parameter logic [31:0] ACTIVE_LOW    = 32'h0000_0001,
    parameter int          DEBOUNCE_LOG2 = 16,
    parameter int          LONG_LOG2     = 24
) (
    input  logic           clk,
    input  logic           rst,
    btn_debounce_if.slave  bus
);
    localparam logic [N_BTN-1:0]         POL_MASK = ACTIVE_LOW[N_BTN-1:0];
    localparam logic [DEBOUNCE_LOG2-1:0] DCNT_MAX = {DEBOUNCE_LOG2{1'b1}};
    localparam logic [DEBOUNCE_LOG2-1:0] DCNT_ONE = {{(DEBOUNCE_LOG2-1){1'b0}}, 1'b1};
    localparam logic [LONG_LOG2-1:0]     HCNT_MAX = {LONG_LOG2{1'b1}};
    localparam logic [LONG_LOG2-1:0]     HCNT_ONE = {{(LONG_LOG2-1){1'b0}}, 1'b1};

    logic [N_BTN-1:0]                    sync1_q, sync2_q;
    logic [N_BTN-1:0]                    state_q, state_d;
    logic [N_BTN-1:0]                    press_q, press_d;
    logic [N_BTN-1:0]                    release_q, release_d;
    logic [N_BTN-1:0]                    long_q, long_d;
    logic [N_BTN-1:0]                    done_q, done_d;
    logic [N_BTN-1:0][DEBOUNCE_LOG2-1:0] dcnt_q, dcnt_d;
    logic [N_BTN-1:0][LONG_LOG2-1:0]     hcnt_q, hcnt_d;

    // Synchroniser; polarity is folded in ahead of the second stage so stage 2 reads 1 = pressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.btn_raw ^ POL_MASK;
            sync2_q <= sync1_q;
        end
    end

    // Debounce and hold-time next-state logic; any return to agreement restarts the count.
    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        hcnt_d    = hcnt_q;
        done_d    = done_q;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (sync2_q[i] == state_q[i]) begin
                dcnt_d[i] = '0;
            end else if (dcnt_q[i] != DCNT_MAX) begin
                dcnt_d[i] = dcnt_q[i] + DCNT_ONE;
            end else begin
                dcnt_d[i]    = '0;
                state_d[i]   = sync2_q[i];
                press_d[i]   = sync2_q[i];
                release_d[i] = ~sync2_q[i];
            end

            if (!state_q[i]) begin
                hcnt_d[i] = '0;
                done_d[i] = 1'b0;
            end else if (!done_q[i]) begin
                if (hcnt_q[i] == HCNT_MAX) begin
                    long_d[i] = 1'b1;
                    done_d[i] = 1'b1;
                end else begin
                    hcnt_d[i] = hcnt_q[i] + HCNT_ONE;
                end
            end else begin
                hcnt_d[i] = hcnt_q[i];
            end
        end
    end

    // Channel state, counters and output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= '0;
            dcnt_q    <= '0;
            hcnt_q    <= '0;
            done_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            hcnt_q    <= hcnt_d;
            done_q    <= done_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign bus.btn_state   = state_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.btn_long    = long_q;
endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with short debounce/hold windows (4 and 16 cycles).
module tb_btn_debounce;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    btn_debounce_if #(.N_BTN(3)) bus ();

    btn_debounce #(
        .N_BTN        (3),
        .ACTIVE_LOW   (32'h0000_0001),
        .DEBOUNCE_LOG2(2),
        .LONG_LOG2    (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges; all driving and sampling happens 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {20'd0, 3'(bus.btn_state), 3'(bus.btn_press), 3'(bus.btn_release), 3'(bus.btn_long)}, 32'd0);
    endtask

    initial begin
        bus.btn_raw = 3'b001;
        step(3);
        // 1: reset, all buttons released
        check_all_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check_all_zero("idle");
        end

        // 2: clean press on channel 1
        bus.btn_raw = 3'b011;
        step(5);
        check_eq("t2_state_early", 32'(bus.btn_state), 32'd0);
        step(1);
        check_eq("t2_state", 32'(bus.btn_state), 32'b010);
        check_eq("t2_press", 32'(bus.btn_press), 32'b010);
        step(1);
        check_eq("t2_press_width", 32'(bus.btn_press), 32'd0);
        bus.btn_raw = 3'b001;
        step(6);
        check_eq("t2_release", 32'(bus.btn_release), 32'b010);
        check_eq("t2_no_long", 32'(bus.btn_long), 32'd0);
        step(1);
        check_eq("t2_release_width", 32'(bus.btn_release), 32'd0);
        step(4);

        // 3: bouncing press on channel 1
        bus.btn_raw = 3'b011; step(1);
        bus.btn_raw = 3'b001; step(1);
        bus.btn_raw = 3'b011; step(1);
        bus.btn_raw = 3'b001; step(1);
        bus.btn_raw = 3'b011;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_eq("t3_no_early_press", {29'd0, 3'(bus.btn_press)}, 32'd0);
            check_eq("t3_state_early", 32'(bus.btn_state), 32'd0);
        end
        step(1);
        check_eq("t3_press", 32'(bus.btn_press), 32'b010);
        step(1);
        check_eq("t3_single", 32'(bus.btn_press), 32'd0);
        bus.btn_raw = 3'b001;
        step(6);
        check_eq("t3_release", 32'(bus.btn_release), 32'b010);
        step(4);

        // 4: active-low press on channel 0, long press then release
        bus.btn_raw = 3'b000;
        step(6);
        check_eq("t4_press", 32'(bus.btn_press), 32'b001);
        check_eq("t4_state", 32'(bus.btn_state), 32'b001);
        for (int i = 0; i < 15; i++) begin
            step(1);
            check_eq("t4_long_early", 32'(bus.btn_long), 32'd0);
        end
        step(1);
        check_eq("t4_long", 32'(bus.btn_long), 32'b001);
        for (int i = 0; i < 7; i++) begin
            step(1);
            check_eq("t4_no_second_long", 32'(bus.btn_long), 32'd0);
        end
        bus.btn_raw = 3'b001;
        step(5);
        check_eq("t4_state_held", 32'(bus.btn_state), 32'b001);
        step(1);
        check_eq("t4_release", 32'(bus.btn_release), 32'b001);
        check_eq("t4_state_off", 32'(bus.btn_state), 32'd0);
        check_eq("t4_no_press", 32'(bus.btn_press), 32'd0);
        step(4);

        // 5: simultaneous press on channels 1 and 2
        bus.btn_raw = 3'b111;
        step(6);
        check_eq("t5_press", 32'(bus.btn_press), 32'b110);
        check_eq("t5_state", 32'(bus.btn_state), 32'b110);
        step(1);
        check_eq("t5_press_width", 32'(bus.btn_press), 32'd0);
        bus.btn_raw = 3'b001;
        step(6);
        check_eq("t5_release", 32'(bus.btn_release), 32'b110);
        step(4);

        // 6: reset in the middle of a hold, button kept pressed
        bus.btn_raw = 3'b011;
        step(6);
        check_eq("t6_press", 32'(bus.btn_press), 32'b010);
        step(5);
        rst = 1'b1;
        #1;
        check_all_zero("t6_reset_clears");
        step(1);
        rst = 1'b0;
        check_all_zero("t6_after_reset");
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_all_zero("t6_no_pulse_on_release_of_reset");
        end
        step(1);
        check_eq("t6_repress", 32'(bus.btn_press), 32'b010);
        check_eq("t6_state", 32'(bus.btn_state), 32'b010);
        for (int i = 0; i < 15; i++) begin
            step(1);
            check_eq("t6_long_early", 32'(bus.btn_long), 32'd0);
        end
        step(1);
        check_eq("t6_long", 32'(bus.btn_long), 32'b010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
